// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front-end: PS/2 event field
// positions, joystick word bit positions, the DIP download index and the
// default keyboard map with its decode helper.
package arcade_input_pkg;

    // hps_io ps2_key fields
    localparam int PS2_TOGGLE   = 10;
    localparam int PS2_PRESSED  = 9;
    localparam int PS2_EXTENDED = 8;

    // Joystick word layout (start and coin sit above the fire buttons)
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_BTN0   = 4;
    localparam int JOY_WORD_W = 16;

    // ioctl index carrying the DIP switch bytes
    localparam logic [7:0] DIP_IOCTL_INDEX = 8'd254;

    // Player 1 directions and buttons
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_BTN0  = 8'h14;
    localparam logic [7:0] SC_P1_BTN1  = 8'h11;
    localparam logic [7:0] SC_P1_BTN2  = 8'h29;
    localparam logic [7:0] SC_P1_BTN3  = 8'h12;

    // Player 2 directions (R/F/D/G) and buttons
    localparam logic [7:0] SC_P2_UP    = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] SC_P2_BTN0  = 8'h1C;
    localparam logic [7:0] SC_P2_BTN1  = 8'h1B;
    localparam logic [7:0] SC_P2_BTN2  = 8'h15;
    localparam logic [7:0] SC_P2_BTN3  = 8'h1D;

    // Players 3 and 4 have buttons only (U/I/O/P and J/K/L/;)
    localparam logic [7:0] SC_P3_BTN0  = 8'h3C;
    localparam logic [7:0] SC_P3_BTN1  = 8'h43;
    localparam logic [7:0] SC_P3_BTN2  = 8'h44;
    localparam logic [7:0] SC_P3_BTN3  = 8'h4D;
    localparam logic [7:0] SC_P4_BTN0  = 8'h3B;
    localparam logic [7:0] SC_P4_BTN1  = 8'h42;
    localparam logic [7:0] SC_P4_BTN2  = 8'h4B;
    localparam logic [7:0] SC_P4_BTN3  = 8'h4C;

    // Starts (1..4 on the number row, F1/F2 as alternates)
    localparam logic [7:0] SC_START1    = 8'h16;
    localparam logic [7:0] SC_START2    = 8'h1E;
    localparam logic [7:0] SC_START3    = 8'h26;
    localparam logic [7:0] SC_START4    = 8'h25;
    localparam logic [7:0] SC_START1_F1 = 8'h05;
    localparam logic [7:0] SC_START2_F2 = 8'h06;

    // Coins (5..8 on the number row, ESC as coin 1 alternate)
    localparam logic [7:0] SC_COIN1     = 8'h2E;
    localparam logic [7:0] SC_COIN2     = 8'h36;
    localparam logic [7:0] SC_COIN3     = 8'h3D;
    localparam logic [7:0] SC_COIN4     = 8'h3E;
    localparam logic [7:0] SC_COIN1_ESC = 8'h76;

    typedef enum logic [1:0] {
        KEY_DIR   = 2'd0,
        KEY_BTN   = 2'd1,
        KEY_START = 2'd2,
        KEY_COIN  = 2'd3
    } key_kind_e;

    // For KEY_DIR, idx is the joystick bit index; for KEY_BTN, the button
    typedef struct packed {
        logic      hit;
        logic [1:0] player;
        key_kind_e kind;
        logic [1:0] idx;
    } key_map_t;

    function automatic key_map_t key_hit(input logic [1:0] player,
                                         input key_kind_e kind,
                                         input logic [1:0] idx);
        key_map_t m;
        m.hit    = 1'b1;
        m.player = player;
        m.kind   = kind;
        m.idx    = idx;
        return m;
    endfunction

    // Translate a scancode into the player/function it controls
    function automatic key_map_t decode_key(input logic [7:0] code);
        key_map_t m;
        m.hit    = 1'b0;
        m.player = 2'd0;
        m.kind   = KEY_DIR;
        m.idx    = 2'd0;
        case (code)
            SC_P1_UP:     m = key_hit(2'd0, KEY_DIR, 2'(JOY_UP));
            SC_P1_DOWN:   m = key_hit(2'd0, KEY_DIR, 2'(JOY_DOWN));
            SC_P1_LEFT:   m = key_hit(2'd0, KEY_DIR, 2'(JOY_LEFT));
            SC_P1_RIGHT:  m = key_hit(2'd0, KEY_DIR, 2'(JOY_RIGHT));
            SC_P1_BTN0:   m = key_hit(2'd0, KEY_BTN, 2'd0);
            SC_P1_BTN1:   m = key_hit(2'd0, KEY_BTN, 2'd1);
            SC_P1_BTN2:   m = key_hit(2'd0, KEY_BTN, 2'd2);
            SC_P1_BTN3:   m = key_hit(2'd0, KEY_BTN, 2'd3);
            SC_P2_UP:     m = key_hit(2'd1, KEY_DIR, 2'(JOY_UP));
            SC_P2_DOWN:   m = key_hit(2'd1, KEY_DIR, 2'(JOY_DOWN));
            SC_P2_LEFT:   m = key_hit(2'd1, KEY_DIR, 2'(JOY_LEFT));
            SC_P2_RIGHT:  m = key_hit(2'd1, KEY_DIR, 2'(JOY_RIGHT));
            SC_P2_BTN0:   m = key_hit(2'd1, KEY_BTN, 2'd0);
            SC_P2_BTN1:   m = key_hit(2'd1, KEY_BTN, 2'd1);
            SC_P2_BTN2:   m = key_hit(2'd1, KEY_BTN, 2'd2);
            SC_P2_BTN3:   m = key_hit(2'd1, KEY_BTN, 2'd3);
            SC_P3_BTN0:   m = key_hit(2'd2, KEY_BTN, 2'd0);
            SC_P3_BTN1:   m = key_hit(2'd2, KEY_BTN, 2'd1);
            SC_P3_BTN2:   m = key_hit(2'd2, KEY_BTN, 2'd2);
            SC_P3_BTN3:   m = key_hit(2'd2, KEY_BTN, 2'd3);
            SC_P4_BTN0:   m = key_hit(2'd3, KEY_BTN, 2'd0);
            SC_P4_BTN1:   m = key_hit(2'd3, KEY_BTN, 2'd1);
            SC_P4_BTN2:   m = key_hit(2'd3, KEY_BTN, 2'd2);
            SC_P4_BTN3:   m = key_hit(2'd3, KEY_BTN, 2'd3);
            SC_START1:    m = key_hit(2'd0, KEY_START, 2'd0);
            SC_START2:    m = key_hit(2'd1, KEY_START, 2'd0);
            SC_START3:    m = key_hit(2'd2, KEY_START, 2'd0);
            SC_START4:    m = key_hit(2'd3, KEY_START, 2'd0);
            SC_START1_F1: m = key_hit(2'd0, KEY_START, 2'd0);
            SC_START2_F2: m = key_hit(2'd1, KEY_START, 2'd0);
            SC_COIN1:     m = key_hit(2'd0, KEY_COIN, 2'd0);
            SC_COIN2:     m = key_hit(2'd1, KEY_COIN, 2'd0);
            SC_COIN3:     m = key_hit(2'd2, KEY_COIN, 2'd0);
            SC_COIN4:     m = key_hit(2'd3, KEY_COIN, 2'd0);
            SC_COIN1_ESC: m = key_hit(2'd0, KEY_COIN, 2'd0);
            default:      m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/coin_stretch.sv
// Coin pulse stretcher: guarantees the registered coin output stays high
// for at least COIN_PULSE_CYCLES clocks after each rising edge of raw.
module coin_stretch #(
    parameter int COIN_PULSE_CYCLES = 240000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw,
    output logic stretched
);

    // The counter is compared before it decrements, so loading N-1 on the
    // edge yields exactly N high cycles including the edge cycle itself.
    localparam int CNT_W = (COIN_PULSE_CYCLES > 1) ? $clog2(COIN_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD =
        (COIN_PULSE_CYCLES > 0) ? CNT_W'(COIN_PULSE_CYCLES - 1) : '0;

    logic             raw_prev;
    logic [CNT_W-1:0] cnt;
    logic             rise;

    assign rise = raw & ~raw_prev;

    // Edge detect, reloadable down-counter saturating at zero, output register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            raw_prev  <= 1'b0;
            cnt       <= '0;
            stretched <= 1'b0;
        end else begin
            raw_prev  <= raw;
            stretched <= raw | (cnt != '0);
            if (rise) begin
                cnt <= RELOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input front-end: merges hps_io PS/2 key events and joystick words
// into registered per-player controls with SOCD cleaning, coin stretching,
// optional player merge and DIP capture from the ioctl download.
// Optional autofire is compiled in with ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS       = 2,
    parameter int NUM_BUTTONS       = 2,
    parameter int COIN_PULSE_CYCLES = 240000,
    parameter int DIP_BYTES         = 8
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    ,
    parameter int AUTOFIRE_HALF     = 600000
`endif
) (
    input  logic                            clk_sys,
    input  logic                            reset,
    input  logic [10:0]                     ps2_key,
    input  logic [NUM_PLAYERS*16-1:0]       joy,
    input  logic                            merge_players,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    input  logic [NUM_BUTTONS-1:0]          autofire_mask,
`endif
    input  logic                            ioctl_wr,
    input  logic [7:0]                      ioctl_index,
    input  logic [24:0]                     ioctl_addr,
    input  logic [7:0]                      ioctl_dout,
    output logic [NUM_PLAYERS*4-1:0]        dir_out,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_out,
    output logic [NUM_PLAYERS-1:0]          start_out,
    output logic [NUM_PLAYERS-1:0]          coin_out,
    output logic [DIP_BYTES*8-1:0]          dip_out
);

    // Key state mirrors the joystick word layout so both can simply be ORed
    localparam int START_BIT = JOY_BTN0 + NUM_BUTTONS;
    localparam int COIN_BIT  = JOY_BTN0 + NUM_BUTTONS + 1;
    localparam int KEY_W     = COIN_BIT + 1;

    // Opposing directions cancel; neither side wins
    function automatic logic [3:0] socd_clean(input logic [3:0] d);
        logic [3:0] c;
        c = d;
        if (d[JOY_LEFT] && d[JOY_RIGHT]) begin
            c[JOY_LEFT]  = 1'b0;
            c[JOY_RIGHT] = 1'b0;
        end
        if (d[JOY_UP] && d[JOY_DOWN]) begin
            c[JOY_UP]   = 1'b0;
            c[JOY_DOWN] = 1'b0;
        end
        return c;
    endfunction

    logic             toggle_prev;
    logic             key_event;
    key_map_t         key_map;
    logic             key_valid;
    logic [3:0]       key_bit;
    logic [KEY_W-1:0] key_state [NUM_PLAYERS];

    logic [NUM_PLAYERS*4-1:0]           dir_raw;
    logic [NUM_PLAYERS*4-1:0]           dir_merged;
    logic [NUM_PLAYERS*4-1:0]           dir_clean;
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_merged;
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_next;
    logic [NUM_PLAYERS-1:0]             start_raw;
    logic [NUM_PLAYERS-1:0]             coin_raw;
    logic [3:0]                         dir_any;
    logic [NUM_BUTTONS-1:0]             btn_any;

    // The extended flag and unused joystick bits are deliberately ignored
    logic unused_inputs;
    assign unused_inputs = ^{ps2_key[PS2_EXTENDED], joy};

    // Event detect and scancode decode; codes for absent players/buttons drop out
    always_comb begin
        key_event = ps2_key[PS2_TOGGLE] ^ toggle_prev;
        key_map   = decode_key(ps2_key[7:0]);
        key_valid = key_map.hit
                    && (int'(key_map.player) < NUM_PLAYERS)
                    && ((key_map.kind != KEY_BTN) || (int'(key_map.idx) < NUM_BUTTONS));
        case (key_map.kind)
            KEY_DIR:   key_bit = {2'b00, key_map.idx};
            KEY_BTN:   key_bit = 4'(JOY_BTN0) + {2'b00, key_map.idx};
            KEY_START: key_bit = 4'(START_BIT);
            default:   key_bit = 4'(COIN_BIT);
        endcase
    end

    // Key-state register: one bit per mapped function, set to the pressed flag
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            toggle_prev <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                key_state[p] <= '0;
            end
        end else begin
            toggle_prev <= ps2_key[PS2_TOGGLE];
            if (key_event && key_valid) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    for (int i = 0; i < KEY_W; i++) begin
                        if (key_map.player == 2'(p) && key_bit == 4'(i)) begin
                            key_state[p][i] <= ps2_key[PS2_PRESSED];
                        end
                    end
                end
            end
        end
    end

    // Raw merge of keys and joystick, optional player merge, then SOCD
    always_comb begin
        dir_raw    = '0;
        dir_merged = '0;
        dir_clean  = '0;
        btn_raw    = '0;
        btn_merged = '0;
        start_raw  = '0;
        coin_raw   = '0;
        dir_any    = '0;
        btn_any    = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int i = 0; i < 4; i++) begin
                dir_raw[p*4+i] = key_state[p][i] | joy[p*JOY_WORD_W+i];
            end
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                btn_raw[p*NUM_BUTTONS+b] = key_state[p][JOY_BTN0+b]
                                           | joy[p*JOY_WORD_W+JOY_BTN0+b];
            end
            start_raw[p] = key_state[p][START_BIT] | joy[p*JOY_WORD_W+START_BIT];
            coin_raw[p]  = key_state[p][COIN_BIT]  | joy[p*JOY_WORD_W+COIN_BIT];
            dir_any = dir_any | dir_raw[p*4+:4];
            btn_any = btn_any | btn_raw[p*NUM_BUTTONS+:NUM_BUTTONS];
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dir_merged[p*4+:4] = merge_players ? dir_any : dir_raw[p*4+:4];
            btn_merged[p*NUM_BUTTONS+:NUM_BUTTONS] =
                merge_players ? btn_any : btn_raw[p*NUM_BUTTONS+:NUM_BUTTONS];
            dir_clean[p*4+:4] = socd_clean(dir_merged[p*4+:4]);
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AF_W = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

    logic [AF_W-1:0]        af_cnt [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] af_low;
    logic [NUM_PLAYERS-1:0] af_held;

    // Masked buttons are gated off during the low half of the autofire phase
    always_comb begin
        af_held  = '0;
        btn_next = btn_merged;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            af_held[p] = |(btn_merged[p*NUM_BUTTONS+:NUM_BUTTONS] & autofire_mask);
            if (af_low[p]) begin
                btn_next[p*NUM_BUTTONS+:NUM_BUTTONS] =
                    btn_merged[p*NUM_BUTTONS+:NUM_BUTTONS] & ~autofire_mask;
            end
        end
    end

    // Per-player phase counter; idle players restart in the high phase
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_low <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                af_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (!af_held[p]) begin
                    af_cnt[p] <= '0;
                    af_low[p] <= 1'b0;
                end else if (af_cnt[p] == AF_W'(AUTOFIRE_HALF - 1)) begin
                    af_cnt[p] <= '0;
                    af_low[p] <= ~af_low[p];
                end else begin
                    af_cnt[p] <= af_cnt[p] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_next = btn_merged;
`endif

    // Output registers for directions, buttons and starts
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dir_out   <= '0;
            btn_out   <= '0;
            start_out <= '0;
        end else begin
            dir_out   <= dir_clean;
            btn_out   <= btn_next;
            start_out <= start_raw;
        end
    end

    // Coins are never merged; each player gets its own stretcher
    for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_coin
        coin_stretch #(
            .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)
        ) u_coin_stretch (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .raw      (coin_raw[gp]),
            .stretched(coin_out[gp])
        );
    end

    // DIP capture from the download stream; out-of-range addresses ignored
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dip_out <= '0;
        end else if (ioctl_wr && ioctl_index == DIP_IOCTL_INDEX
                     && ioctl_addr < 25'(DIP_BYTES)) begin
            for (int k = 0; k < DIP_BYTES; k++) begin
                if (ioctl_addr == 25'(k)) begin
                    dip_out[k*8+:8] <= ioctl_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed testbench for arcade_input_mapper (2 players, 2 buttons,
// 16-cycle coin pulse, 8 DIP bytes). Joystick bits per player with two
// buttons: [0]R [1]L [2]D [3]U [4]B0 [5]B1 [6]start [7]coin.
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int NB = 2;
    localparam int CP = 16;
    localparam int DB = 8;

    logic               clk_sys = 1'b0;
    logic               reset = 1'b1;
    logic [10:0]        ps2_key = '0;
    logic [NP*16-1:0]   joy = '0;
    logic               merge_players = 1'b0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [NB-1:0]      autofire_mask = '0;
`endif
    logic               ioctl_wr = 1'b0;
    logic [7:0]         ioctl_index = '0;
    logic [24:0]        ioctl_addr = '0;
    logic [7:0]         ioctl_dout = '0;
    logic [NP*4-1:0]    dir_out;
    logic [NP*NB-1:0]   btn_out;
    logic [NP-1:0]      start_out;
    logic [NP-1:0]      coin_out;
    logic [DB*8-1:0]    dip_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS      (NP),
        .NUM_BUTTONS      (NB),
        .COIN_PULSE_CYCLES(CP),
        .DIP_BYTES        (DB)
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        ,
        .AUTOFIRE_HALF    (4)
`endif
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_key      (ps2_key),
        .joy          (joy),
        .merge_players(merge_players),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        .autofire_mask(autofire_mask),
`endif
        .ioctl_wr     (ioctl_wr),
        .ioctl_index  (ioctl_index),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .dir_out      (dir_out),
        .btn_out      (btn_out),
        .start_out    (start_out),
        .coin_out     (coin_out),
        .dip_out      (dip_out)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (dir_out !== 8'h00) begin errors++; $display("FAIL reset_dir: got %h expected %h", dir_out, 8'h00); end
        checks++; if (btn_out !== 4'h0) begin errors++; $display("FAIL reset_btn: got %h expected %h", btn_out, 4'h0); end
        checks++; if (start_out !== 2'b00) begin errors++; $display("FAIL reset_start: got %b expected %b", start_out, 2'b00); end
        checks++; if (coin_out !== 2'b00) begin errors++; $display("FAIL reset_coin: got %b expected %b", coin_out, 2'b00); end
        checks++; if (dip_out !== 64'h0) begin errors++; $display("FAIL reset_dip: got %h expected %h", dip_out, 64'h0); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ps2_key();
        send_key(1'b1, 8'h75);
        tick();
        checks++; if (dir_out !== 8'h00) begin errors++; $display("FAIL key_up_lat1: got %h expected %h", dir_out, 8'h00); end
        tick();
        checks++; if (dir_out !== 8'h08) begin errors++; $display("FAIL key_up_press: got %h expected %h", dir_out, 8'h08); end
        send_key(1'b0, 8'h75);
        tick();
        tick();
        checks++; if (dir_out !== 8'h00) begin errors++; $display("FAIL key_up_release: got %h expected %h", dir_out, 8'h00); end
        send_key(1'b1, 8'h2D);
        tick();
        tick();
        checks++; if (dir_out !== 8'h80) begin errors++; $display("FAIL key_p2_up: got %h expected %h", dir_out, 8'h80); end
        send_key(1'b0, 8'h2D);
        send_key(1'b1, 8'h06);
        tick();
        checks++; if (dir_out !== 8'h80) begin errors++; $display("FAIL key_p2_up_hold: got %h expected %h", dir_out, 8'h80); end
        tick();
        checks++; if (start_out !== 2'b00) begin errors++; $display("FAIL key_no_event: got %b expected %b", start_out, 2'b00); end
        send_key(1'b1, 8'h05);
        tick();
        tick();
        checks++; if (start_out !== 2'b01) begin errors++; $display("FAIL key_f1_start1: got %b expected %b", start_out, 2'b01); end
        send_key(1'b0, 8'h05);
        tick();
        send_key(1'b0, 8'h2D);
        tick();
        tick();
        checks++; if (dir_out !== 8'h00 || start_out !== 2'b00) begin errors++; $display("FAIL key_all_release: got dir %h start %b expected 00 00", dir_out, start_out); end
        send_key(1'b1, 8'h76);
        tick();
        tick();
        checks++; if (coin_out !== 2'b01) begin errors++; $display("FAIL key_esc_coin1: got %b expected %b", coin_out, 2'b01); end
        send_key(1'b0, 8'h76);
        for (int i = 0; i < 20; i++) tick();
        checks++; if (coin_out !== 2'b00) begin errors++; $display("FAIL key_coin_expire: got %b expected %b", coin_out, 2'b00); end
    endtask

    task automatic test_back_to_back();
        send_key(1'b1, 8'h14);
        tick();
        send_key(1'b1, 8'h1B);
        tick();
        checks++; if (btn_out !== 4'b0001) begin errors++; $display("FAIL b2b_first: got %b expected %b", btn_out, 4'b0001); end
        tick();
        checks++; if (btn_out !== 4'b1001) begin errors++; $display("FAIL b2b_both: got %b expected %b", btn_out, 4'b1001); end
        send_key(1'b1, 8'h5A);
        tick();
        send_key(1'b1, 8'h3C);
        tick();
        send_key(1'b1, 8'h29);
        tick();
        tick();
        checks++; if (btn_out !== 4'b1001 || dir_out !== 8'h00 || start_out !== 2'b00) begin errors++; $display("FAIL b2b_unmapped: got btn %b dir %h start %b expected 1001 00 00", btn_out, dir_out, start_out); end
        send_key(1'b0, 8'h14);
        tick();
        send_key(1'b0, 8'h1B);
        tick();
        tick();
        checks++; if (btn_out !== 4'b0000) begin errors++; $display("FAIL b2b_release: got %b expected %b", btn_out, 4'b0000); end
    endtask

    task automatic test_socd();
        joy[1:0] = 2'b11;
        joy[19:18] = 2'b11;
        joy[16] = 1'b1;
        tick();
        checks++; if (dir_out !== 8'h10) begin errors++; $display("FAIL socd_cancel: got %h expected %h", dir_out, 8'h10); end
        joy[0] = 1'b0;
        tick();
        checks++; if (dir_out !== 8'h12) begin errors++; $display("FAIL socd_left_only: got %h expected %h", dir_out, 8'h12); end
        joy = '0;
        tick();
        checks++; if (dir_out !== 8'h00) begin errors++; $display("FAIL socd_clear: got %h expected %h", dir_out, 8'h00); end
    endtask

    task automatic test_coin_stretch();
        logic [39:0] hist;
        int highs;
        hist = '0;
        highs = 0;
        joy[7] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) joy[7] = 1'b0;
            tick();
            hist[i] = coin_out[0];
            if (coin_out[0]) highs++;
            checks++; if (coin_out[1] !== 1'b0) begin errors++; $display("FAIL coin_p2_quiet: got %b expected 0 at %0d", coin_out[1], i); end
        end
        checks++; if (highs != 16 || hist[15] !== 1'b1 || hist[16] !== 1'b0) begin errors++; $display("FAIL coin_single: got %0d high cycles expected 16 contiguous from 0"
                                                                                                    , highs); end
        hist = '0;
        highs = 0;
        joy[7] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 2 || i == 12) joy[7] = 1'b0;
            if (i == 10) joy[7] = 1'b1;
            tick();
            hist[i] = coin_out[0];
            if (coin_out[0]) highs++;
        end
        checks++; if (highs != 26 || hist[25] !== 1'b1 || hist[26] !== 1'b0) begin errors++; $display("FAIL coin_retrigger: got %0d high cycles expected 26 contiguous from 0", highs); end
    endtask

    task automatic test_dip();
        for (int a = 0; a < 10; a++) begin
            ioctl_wr = 1'b1;
            ioctl_index = 8'd254;
            ioctl_addr = 25'(a);
            ioctl_dout = 8'hA0 + 8'(a);
            tick();
        end
        ioctl_index = 8'd0;
        ioctl_addr = 25'd3;
        ioctl_dout = 8'hFF;
        tick();
        ioctl_wr = 1'b0;
        ioctl_index = 8'd254;
        ioctl_addr = 25'd5;
        ioctl_dout = 8'h55;
        tick();
        checks++; if (dip_out !== 64'hA7A6A5A4A3A2A1A0) begin errors++; $display("FAIL dip_capture: got %h expected %h", dip_out, 64'hA7A6A5A4A3A2A1A0); end
        ioctl_index = 8'd0;
        ioctl_addr = '0;
        ioctl_dout = '0;
    endtask

    task automatic test_merge();
        merge_players = 1'b1;
        joy[20] = 1'b1;
        tick();
        checks++; if (btn_out !== 4'b0101) begin errors++; $display("FAIL merge_btn0: got %b expected %b", btn_out, 4'b0101); end
        joy[22] = 1'b1;
        tick();
        checks++; if (start_out !== 2'b10) begin errors++; $display("FAIL merge_start_unmerged: got %b expected %b", start_out, 2'b10); end
        joy = '0;
        joy[0] = 1'b1;
        joy[17] = 1'b1;
        tick();
        checks++; if (dir_out !== 8'h00) begin errors++; $display("FAIL merge_socd: got %h expected %h", dir_out, 8'h00); end
        joy = '0;
        joy[3] = 1'b1;
        tick();
        checks++; if (dir_out !== 8'h88) begin errors++; $display("FAIL merge_up: got %h expected %h", dir_out, 8'h88); end
        merge_players = 1'b0;
        joy = '0;
        joy[21] = 1'b1;
        tick();
        checks++; if (btn_out !== 4'b1000 || dir_out !== 8'h00) begin errors++; $display("FAIL merge_off: got btn %b dir %h expected 1000 00", btn_out, dir_out); end
        joy = '0;
        tick();
    endtask

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    task automatic test_autofire();
        logic exp_b;
        autofire_mask = 2'b01;
        joy[4] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_b = ((i / 4) % 2) == 0;
            checks++; if (btn_out[0] !== exp_b) begin errors++; $display("FAIL autofire_pattern: got %b expected %b at %0d", btn_out[0], exp_b, i); end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (btn_out !== 4'b0000) begin errors++; $display("FAIL autofire_reset: got %b expected %b", btn_out, 4'b0000); end
        tick();
        reset = 1'b0;
        joy = '0;
        autofire_mask = '0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        joy[7] = 1'b1;
        tick();
        joy[7] = 1'b0;
        send_key(1'b1, 8'h75);
        tick();
        tick();
        // Park an unmapped code so the post-reset toggle mismatch decodes to nothing
        ps2_key[7:0] = 8'h00;
        checks++; if (dir_out !== 8'h08 || coin_out !== 2'b01) begin errors++; $display("FAIL mid_before: got dir %h coin %b expected 08 01", dir_out, coin_out); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dir_out !== 8'h00 || coin_out !== 2'b00 || dip_out !== 64'h0) begin errors++; $display("FAIL mid_async: got dir %h coin %b dip %h expected 00 00 0", dir_out, coin_out, dip_out); end
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (dir_out !== 8'h00) begin errors++; $display("FAIL mid_key_released: got %h expected %h", dir_out, 8'h00); end
        checks++; if (coin_out !== 2'b00) begin errors++; $display("FAIL mid_coin_cleared: got %b expected %b", coin_out, 2'b00); end
        checks++; if (dip_out !== 64'h0) begin errors++; $display("FAIL mid_dip_cleared: got %h expected %h", dip_out, 64'h0); end
    endtask

    initial begin
        test_reset();
        test_ps2_key();
        test_back_to_back();
        test_socd();
        test_coin_stretch();
        test_dip();
        test_merge();
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        test_autofire();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
